// File: rtl/param_register_file_pkg.sv
// Shared definitions for the pipelined CPU register file: default widths,
// architectural register numbers and the byte-enable width helper.
package param_register_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/param_register_file_reg_scoreboard.sv
// Per-register busy scoreboard: mark on issue, clear on writeback, with a
// newer mark winning over a same-edge clear.
module reg_scoreboard
  import param_register_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mark_en,
  input  logic [ADDR_W-1:0] i_mark_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_busy_any
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W-1:0]   w_rd_addr [2];
  logic                w_busy    [2];

  // Clear applied first so a same-edge mark of the same register overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en)
      w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_mark_en)
      w_busy_nxt[i_mark_addr] = 1'b1;
    if (ZERO_REG != 0)
      w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign w_rd_addr[0] = i_rd_addr1;
  assign w_rd_addr[1] = i_rd_addr2;

  // A register being cleared this cycle is forwarded, so decode need not stall.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_busy[p] = r_busy[w_rd_addr[p]];
      if (BYPASS != 0 && i_clr_en && i_clr_addr == w_rd_addr[p])
        w_busy[p] = 1'b0;
      if (ZERO_REG != 0 && w_rd_addr[p] == '0)
        w_busy[p] = 1'b0;
    end
  end

  assign o_busy1    = w_busy[0];
  assign o_busy2    = w_busy[1];
  assign o_busy_any = |r_busy;

endmodule

// File: rtl/param_register_file.sv
// Register file for the pipelined CPU: two combinational read ports, one
// byte-enabled write port with optional bypass, and a busy scoreboard.
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          CLK_in,
  input  logic                          RSTn_in,
  input  logic [ADDR_W-1:0]             RegRead1,
  input  logic [ADDR_W-1:0]             RegRead2,
  output logic [DATA_W-1:0]             ReadData1,
  output logic [DATA_W-1:0]             ReadData2,
  output logic                          Busy1,
  output logic                          Busy2,
  input  logic                          RegWrite_en,
  input  logic [ADDR_W-1:0]             RegWrite,
  input  logic [be_width(DATA_W)-1:0]   RegWrite_be,
  input  logic [DATA_W-1:0]             RegWriteData,
  input  logic                          WriteClear,
  input  logic                          Mark_en,
  input  logic [ADDR_W-1:0]             Mark_addr,
  output logic                          BusyAny
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int BE_W     = be_width(DATA_W);

  logic [DATA_W-1:0] w_regs    [NUM_REGS];
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign w_regs[i] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] r_data;

      always_ff @(posedge CLK_in or negedge RSTn_in) begin
        if (!RSTn_in)
          r_data <= '0;
        else if (RegWrite_en && RegWrite == ADDR_W'(i))
          for (int unsigned b = 0; b < BE_W; b++)
            if (RegWrite_be[b])
              r_data[b*8 +: 8] <= RegWriteData[b*8 +: 8];
      end

      assign w_regs[i] = r_data;
    end
  end

  assign w_rd_addr[0] = RegRead1;
  assign w_rd_addr[1] = RegRead2;

  // Reset also masks the bypass path so outputs read zero throughout reset.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_rd_data[p] = w_regs[w_rd_addr[p]];
      if (BYPASS != 0 && RegWrite_en && RegWrite == w_rd_addr[p])
        for (int unsigned b = 0; b < BE_W; b++)
          if (RegWrite_be[b])
            w_rd_data[p][b*8 +: 8] = RegWriteData[b*8 +: 8];
      if ((ZERO_REG != 0 && w_rd_addr[p] == '0) || !RSTn_in)
        w_rd_data[p] = '0;
    end
  end

  assign ReadData1 = w_rd_data[0];
  assign ReadData2 = w_rd_data[1];

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .i_clk       (CLK_in),
    .i_rst_n     (RSTn_in),
    .i_mark_en   (Mark_en),
    .i_mark_addr (Mark_addr),
    .i_clr_en    (RegWrite_en & WriteClear),
    .i_clr_addr  (RegWrite),
    .i_rd_addr1  (RegRead1),
    .i_rd_addr2  (RegRead2),
    .o_busy1     (Busy1),
    .o_busy2     (Busy2),
    .o_busy_any  (BusyAny)
  );

endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed check of param_register_file (BYPASS=1 and BYPASS=0
// builds driven in parallel) against an array-based reference model.
module tb_param_register_file;
  import param_register_file_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd1, rd2, wa, ma;
  logic        we, wc, mk;
  logic [3:0]  be;
  logic [31:0] wd;

  logic [31:0] d1, d2, nb_d1, nb_d2;
  logic        b1, b2, bany, nb_b1, nb_b2, nb_bany;

  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  int n_checks = 0;
  int n_fail   = 0;

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .CLK_in(clk), .RSTn_in(rst_n), .RegRead1(rd1), .RegRead2(rd2),
    .ReadData1(d1), .ReadData2(d2), .Busy1(b1), .Busy2(b2),
    .RegWrite_en(we), .RegWrite(wa), .RegWrite_be(be), .RegWriteData(wd),
    .WriteClear(wc), .Mark_en(mk), .Mark_addr(ma), .BusyAny(bany)
  );

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .CLK_in(clk), .RSTn_in(rst_n), .RegRead1(rd1), .RegRead2(rd2),
    .ReadData1(nb_d1), .ReadData2(nb_d2), .Busy1(nb_b1), .Busy2(nb_b2),
    .RegWrite_en(we), .RegWrite(wa), .RegWrite_be(be), .RegWriteData(wd),
    .WriteClear(wc), .Mark_en(mk), .Mark_addr(ma), .BusyAny(nb_bany)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] e);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (e[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (!rst_n || a == 5'd0) return 32'd0;
    v = m_mem[a];
    if (byp && we && wa == a)
      v = (v & ~be_mask(be)) | (wd & be_mask(be));
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (byp && we && wc && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | m_busy[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one rising edge: clear before mark, r0 immutable.
  task automatic model_commit();
    if (we && wa != 5'd0)
      m_mem[wa] = (m_mem[wa] & ~be_mask(be)) | (wd & be_mask(be));
    if (we && wc) m_busy[wa] = 1'b0;
    if (mk && ma != 5'd0) m_busy[ma] = 1'b1;
  endtask

  task automatic drive(input logic iwe, input logic [4:0] iwa, input logic [3:0] ibe,
                       input logic [31:0] iwd, input logic iwc, input logic imk,
                       input logic [4:0] ima, input logic [4:0] ir1, input logic [4:0] ir2);
    we = iwe; wa = iwa; be = ibe; wd = iwd; wc = iwc;
    mk = imk; ma = ima; rd1 = ir1; rd2 = ir2;
  endtask

  task automatic settle();
    #1;
    check("rd1",     d1,      exp_read(rd1, 1'b1));
    check("rd2",     d2,      exp_read(rd2, 1'b1));
    check("busy1",   32'(b1), 32'(exp_busy(rd1, 1'b1)));
    check("busy2",   32'(b2), 32'(exp_busy(rd2, 1'b1)));
    check("busyany", 32'(bany), 32'(exp_any()));
    check("nb_rd1",  nb_d1,   exp_read(rd1, 1'b0));
    check("nb_rd2",  nb_d2,   exp_read(rd2, 1'b0));
    check("nb_busy1", 32'(nb_b1), 32'(exp_busy(rd1, 1'b0)));
    check("nb_busy2", 32'(nb_b2), 32'(exp_busy(rd2, 1'b0)));
    check("nb_busyany", 32'(nb_bany), 32'(exp_any()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_commit();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    settle();
    rst_n = 1'b1;

    // Reset asserted mid-cycle after r5 written and r6 marked
    drive(1, 5, 4'hF, 32'hDEADBEEF, 0, 1, 6, 5, 6); settle(); tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 5, 6); settle();
    check("pre_rst_r5", d1, 32'hDEADBEEF);
    check("pre_rst_busy6", 32'(b2), 32'd1);
    rst_n = 1'b0;
    model_reset();
    settle();
    check("rst_r5", d1, 32'h0);
    check("rst_busy", 32'(b2), 32'd0);
    check("rst_busyany", 32'(bany), 32'd0);

    // Write during reset is lost
    drive(1, 8, 4'hF, 32'hCAFEF00D, 0, 1, 8, 8, 8); settle(); tick();
    rst_n = 1'b1;
    drive(0, 0, 4'h0, 0, 0, 0, 0, 8, 8); settle();
    check("rst_write_lost", d1, 32'h0);
    tick();

    // Byte-enabled write with same-cycle bypass
    drive(1, 3, 4'hF, 32'h11223344, 0, 0, 0, 3, 3); settle(); tick();
    drive(1, 3, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 0, 3); settle();
    check("byte_bypass", d2, 32'h11BB33DD);
    check("byte_nobypass", nb_d2, 32'h11223344);
    tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 3, 0); settle();
    check("byte_stored", d1, 32'h11BB33DD);
    tick();

    // r0 hardwired
    drive(1, 0, 4'hF, 32'hFFFFFFFF, 0, 1, 0, 0, 0); settle();
    check("zero_bypass", d1, 32'h0);
    tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 0, 0); settle();
    check("zero_rd", d1, 32'h0);
    check("zero_busy", 32'(b1), 32'd0);
    check("zero_busyany", 32'(bany), 32'd0);
    tick();

    // Scoreboard mark then writeback clear
    drive(0, 0, 4'h0, 0, 0, 1, 7, 0, 7); settle();
    check("mark_not_bypassed", 32'(b2), 32'd0);
    tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 0, 7); settle();
    check("mark_busy", 32'(b2), 32'd1);
    tick();
    drive(1, 7, 4'hF, 32'h5, 1, 0, 0, 0, 7); settle();
    check("clr_busy", 32'(b2), 32'd0);
    check("clr_data", d2, 32'h5);
    check("clr_nb_busy", 32'(nb_b2), 32'd1);
    tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 0, 7); settle();
    check("clr_busyany", 32'(bany), 32'd0);
    tick();

    // Set/clear collision: set wins
    drive(0, 0, 4'h0, 0, 0, 1, 9, 9, 9); settle(); tick();
    drive(1, 9, 4'hF, 32'h99, 1, 1, 9, 9, 9); settle(); tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 9, 9); settle();
    check("collide_busy", 32'(b1), 32'd1);
    check("collide_data", d1, 32'h99);
    tick();

    // BYPASS=0 latency
    drive(1, 4, 4'hF, 32'h12, 0, 0, 0, 4, 4); settle();
    check("nb_old", nb_d1, 32'h0);
    tick();
    drive(0, 0, 4'h0, 0, 0, 0, 0, 4, 4); settle();
    check("nb_new", nb_d1, 32'h12);
    tick();

    // Random traffic biased to a few registers for frequent collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rw, rm, r1, r2;
      rw = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rm = 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 1) == 0) ? rw : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 2) == 0) ? rm : 5'($urandom);
      drive(1'($urandom), rw, 4'($urandom), $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0), rm, r1, r2);
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
